// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl: 16550-style host register front end that configures and sequences one tx_rx datapath.
// Latency: bus_rdata/read_flag one cycle after bus_rd; write_flag one cycle after the LOAD state; irq lags its source by one cycle.
// Backpressure: none on the host bus; a THR write while THRE=0 is dropped. Optional loopback via `UART_LOOPBACK_EN.
module uart_reg_ctrl #(
   parameter logic [15:0] DIV_RESET = 16'd5208,
   parameter logic [7:0]  LCR_RESET = 8'h03
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  bus_addr,
   input  logic        bus_wr,
   input  logic        bus_rd,
   input  logic [7:0]  bus_wdata,
   output logic [7:0]  bus_rdata,
   output logic        irq,
   output logic [1:0]  word_length,
   output logic        stop_bits,
   output logic [2:0]  parity,
   output logic        set_break,
   output logic [15:0] baud_rate_cnt,
   output logic [7:0]  pi_tx_data,
   output logic        write_flag,
   output logic        read_flag,
   input  logic [7:0]  po_rx_data,
   input  logic        data_ready,
   input  logic        parity_error,
   input  logic        line_rx,
   output logic        line_tx,
   output logic        core_rx,
   input  logic        core_tx
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_BUSY} tx_state_t;

   tx_state_t   state_q;
   logic [7:0]  lcr_q, dll_q, dlm_q, scr_q, thr_q;
   logic [2:0]  ier_q;
   logic        thre_q, pe_q, dr_prev_q, pend_q;
   logic [19:0] timer_q;
   logic [7:0]  rdata_q, pi_tx_data_q;
   logic        irq_q, write_flag_q, read_flag_q;
   logic [7:0]  mcr_rd;

   logic        dlab, temt, rd_any;
   logic        wr_thr, thr_accept, wr_ier, rd_lsr, rd_iir;
   logic [7:0]  lsr, iir, rdata_d;
   logic [3:0]  frame_bits;
   logic [19:0] frame_len;

   assign dlab       = lcr_q[7];
   assign temt       = thre_q & (state_q == ST_IDLE);
   assign lsr        = {1'b0, temt, thre_q, 2'b00, pe_q, 1'b0, data_ready};
   // a simultaneous write wins, so the read side is qualified by ~bus_wr
   assign rd_any     = bus_rd & ~bus_wr;
   assign wr_thr     = bus_wr & (bus_addr == 3'd0) & ~dlab;
   assign thr_accept = wr_thr & thre_q;
   assign wr_ier     = bus_wr & (bus_addr == 3'd1) & ~dlab;
   assign rd_lsr     = rd_any & (bus_addr == 3'd5);
   assign rd_iir     = rd_any & (bus_addr == 3'd2);
   // frame = start + data(5..8) + parity + stop(1..2) bits, each baud_rate_cnt cycles
   assign frame_bits = 4'd7 + {2'b00, lcr_q[1:0]} + {3'b000, lcr_q[3]} + {3'b000, lcr_q[2]};
   assign frame_len  = 20'(frame_bits) * {4'h0, dlm_q, dll_q};

   assign word_length   = lcr_q[1:0];
   assign stop_bits     = lcr_q[2];
   assign parity        = lcr_q[5:3];
   assign set_break     = lcr_q[6];
   assign baud_rate_cnt = {dlm_q, dll_q};
   assign bus_rdata     = rdata_q;
   assign irq           = irq_q;
   assign write_flag    = write_flag_q;
   assign read_flag     = read_flag_q;
   assign pi_tx_data    = pi_tx_data_q;

`ifdef UART_LOOPBACK_EN
   logic mcr_lb_q;
   assign mcr_rd  = {3'b000, mcr_lb_q, 4'h0};
   assign core_rx = mcr_lb_q ? core_tx : line_rx;
   assign line_tx = mcr_lb_q ? 1'b1 : core_tx;

   // MCR loopback bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              mcr_lb_q <= 1'b0;
      else if (bus_wr && bus_addr == 3'd4)     mcr_lb_q <= bus_wdata[4];
   end
`else
   assign mcr_rd  = 8'h00;
   assign core_rx = line_rx;
   assign line_tx = core_tx;
`endif

   // interrupt identification, highest priority first
   always_comb begin
      iir = 8'h01;
      if (pe_q && ier_q[2])             iir = 8'h06;
      else if (data_ready && ier_q[0])  iir = 8'h04;
      else if (pend_q && ier_q[1])      iir = 8'h02;
   end

   // read data mux
   always_comb begin
      rdata_d = 8'h00;
      case (bus_addr)
         3'd0: rdata_d = dlab ? dll_q : po_rx_data;
         3'd1: rdata_d = dlab ? dlm_q : {5'b00000, ier_q};
         3'd2: rdata_d = iir;
         3'd3: rdata_d = lcr_q;
         3'd4: rdata_d = mcr_rd;
         3'd5: rdata_d = lsr;
         3'd6: rdata_d = 8'h00;
         default: rdata_d = scr_q;
      endcase
   end

   // host-writable configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcr_q <= LCR_RESET;
         dll_q <= DIV_RESET[7:0];
         dlm_q <= DIV_RESET[15:8];
         ier_q <= 3'b000;
         scr_q <= 8'h00;
      end else if (bus_wr) begin
         case (bus_addr)
            3'd0: if (dlab) dll_q <= bus_wdata;
            3'd1: if (dlab) dlm_q <= bus_wdata; else ier_q <= bus_wdata[2:0];
            3'd3: lcr_q <= bus_wdata;
            3'd7: scr_q <= bus_wdata;
            default: ;
         endcase
      end
   end

   // transmit sequencer: holding register, frame timer and start pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         thr_q        <= 8'h00;
         thre_q       <= 1'b1;
         timer_q      <= 20'd0;
         write_flag_q <= 1'b0;
         pi_tx_data_q <= 8'h00;
      end else begin
         write_flag_q <= 1'b0;
         if (thr_accept) begin
            thr_q  <= bus_wdata;
            thre_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: if (thr_accept) state_q <= ST_LOAD;
            ST_LOAD: begin
               pi_tx_data_q <= thr_q;
               write_flag_q <= 1'b1;
               thre_q       <= 1'b1;
               timer_q      <= frame_len;
               state_q      <= ST_BUSY;
            end
            ST_BUSY: begin
               // LOAD plus frame_len BUSY cycles; a zero-length frame still spends one BUSY cycle
               if (timer_q <= 20'd1) begin
                  timer_q <= 20'd0;
                  state_q <= (!thre_q || thr_accept) ? ST_LOAD : ST_IDLE;
               end else begin
                  timer_q <= timer_q - 20'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // status latches, interrupt output and registered read port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dr_prev_q   <= 1'b0;
         pe_q        <= 1'b0;
         pend_q      <= 1'b0;
         irq_q       <= 1'b0;
         rdata_q     <= 8'h00;
         read_flag_q <= 1'b0;
      end else begin
         dr_prev_q   <= data_ready;
         irq_q       <= ~iir[0];
         read_flag_q <= rd_any && (bus_addr == 3'd0) && !dlab;
         if (rd_any) rdata_q <= rdata_d;
         // set beats clear for both latches
         if (data_ready && !dr_prev_q && parity_error) pe_q <= 1'b1;
         else if (rd_lsr)                              pe_q <= 1'b0;
         if ((state_q == ST_LOAD) || (wr_ier && bus_wdata[1] && thre_q)) pend_q <= 1'b1;
         else if (wr_thr || (rd_iir && iir == 8'h02))                   pend_q <= 1'b0;
      end
   end

endmodule
